asym_fifo_wide_wr: RTL and testbench
====================================

// Module: asym_fifo_wide_wr
// PURPOSE
//  Parametrised asymmetric FIFO: writes RATIO narrow words per push, reads one narrow word per pop.
//  Adds full/empty/count control, overflow/underflow reporting and selectable slice order.
//  Sits between a wide producer (e.g. 16/32-bit bus) and a byte-wide consumer (e.g. UART TX path).
// PARAMETERS
//  ADDR_WIDTH    4  log2 of storage depth in narrow words; must be >= log2(RATIO)+1
//  DATA_WIDTH    8  narrow (read) word width in bits
//  RATIO         2  narrow words per write; power of 2, >= 2
//  WR_MSB_FIRST  1  1: upper slice of w_data is read first; 0: lower slice is read first
// PORTS
//  clk       in   1                    system clock, rising edge
//  reset_n   in   1                    asynchronous, active-low reset
//  wr        in   1                    push request (one wide word)
//  w_data    in   RATIO*DATA_WIDTH     wide write data
//  rd        in   1                    pop request (one narrow word)
//  r_data    out  DATA_WIDTH           head narrow word (show-ahead)
//  full      out  1                    fewer than RATIO free narrow slots
//  empty     out  1                    zero narrow words stored
//  count     out  ADDR_WIDTH+1         narrow words stored, 0..2**ADDR_WIDTH
//  ovf       out  1                    1-cycle pulse: wr while full (write dropped)
//  udf       out  1                    1-cycle pulse: rd while empty (read dropped)
// BEHAVIOUR
//  - Reset (async assert, sync release): w_ptr=0, r_ptr=0, count=0, empty=1, full=0, ovf=0,
//    udf=0, r_data=0. Memory contents not reset.
//  - Storage: 2**ADDR_WIDTH x DATA_WIDTH array. w_ptr steps by RATIO, always a multiple of RATIO;
//    r_ptr steps by 1. Both wrap modulo 2**ADDR_WIDTH.
//  - Write accepted when wr && !full: slice k (k=0..RATIO-1) lands at w_ptr+k. With WR_MSB_FIRST=1,
//    slice k = w_data[(RATIO-k)*DW-1 -: DW]; with 0, slice k = w_data[(k+1)*DW-1 -: DW].
//  - Read accepted when rd && !empty: r_ptr advances by 1 on the clock edge.
//  - r_data = mem[r_ptr] combinationally when !empty; forced to 0 when empty. No read latency:
//    a word written at edge N is visible on r_data after edge N.
//  - Flags are registered, derived from next count: empty = (count==0);
//    full = (count > 2**ADDR_WIDTH - RATIO).
//  - count update per edge: +RATIO on accepted write, -1 on accepted read, +RATIO-1 on both.
//  - Simultaneous wr && rd: acceptance uses pre-edge full/empty; a read never unblocks a
//    same-cycle write, and a write never satisfies a same-cycle read when empty.
//  - Dropped ops change no state except pulse flags: ovf=1 on the edge after wr && full;
//    udf=1 on the edge after rd && empty; both return to 0 the following cycle unless repeated.
//  - Wrap-around: w_ptr alignment guarantees a wide write never straddles the array end.
//  - Reset mid-operation: all state returns to reset values immediately; stored data is
//    discarded logically (count=0).
//  - Output registers: full, empty, count, ovf, udf. r_data is combinational from r_ptr/empty.
// TESTING (defaults ADDR_WIDTH=4, DATA_WIDTH=8, RATIO=2)
//  1 Reset, write 16'hA1B2 once -> count=2, empty=0; r_data=8'hA1; pop -> 8'hB2; pop -> empty=1, r_data=0.
//  2 Eight writes 16'h0001..16'h0008 -> full=1 after the 8th, count=16; 9th write -> ovf pulse,
//    count stays 16; drain 16 reads -> sequence 00,01,00,02,...,00,08.
//  3 With count=15 (full=1), assert wr and rd together -> read accepted, write dropped,
//    ovf=1, count=14, full=0 next cycle.
//  4 Empty FIFO, assert rd -> udf pulses exactly one cycle, r_ptr/count unchanged;
//    wr+rd together while empty -> write taken, read dropped, udf=1, count=2.
//  5 Wrap test: fill 16, read 6, write 3 more, read all -> order preserved across index 15->0.
//  6 Assert reset_n=0 mid-stream (count=7) between edges -> count=0, empty=1, r_data=0
//    immediately; WR_MSB_FIRST=0 build: write 16'hA1B2 -> first read 8'hB2.

Source files
------------

// File: rtl/asym_fifo_wide_wr_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | asym_fifo_wide_wr_if : handshake bundle for the wide-write/narrow-read FIFO |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
interface asym_fifo_wide_wr_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int RATIO      = 2
);
    logic                          wr;
    logic [RATIO*DATA_WIDTH-1:0]   w_data;
    logic                          rd;
    logic [DATA_WIDTH-1:0]         r_data;
    logic                          full;
    logic                          empty;
    logic [ADDR_WIDTH:0]           count;
    logic                          ovf;
    logic                          udf;

    modport master (
        output wr, w_data, rd,
        input  r_data, full, empty, count, ovf, udf
    );

    modport slave (
        input  wr, w_data, rd,
        output r_data, full, empty, count, ovf, udf
    );
endinterface
`default_nettype wire

// File: rtl/asym_fifo_wide_wr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | asym_fifo_wide_wr : FIFO taking RATIO narrow words per push, one per pop    |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module asym_fifo_wide_wr #(
    parameter int ADDR_WIDTH   = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int RATIO        = 2,
    parameter int WR_MSB_FIRST = 1
) (
    input  wire logic            clk,
    input  wire logic            reset_n,
    asym_fifo_wide_wr_if.slave   bus
);

    localparam int                  c_depth       = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] c_ratio_cnt   = (ADDR_WIDTH+1)'(RATIO);
    localparam logic [ADDR_WIDTH:0] c_one_cnt     = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] c_full_thresh = (ADDR_WIDTH+1)'(c_depth - RATIO);
    localparam logic [ADDR_WIDTH-1:0] c_ratio_ptr = ADDR_WIDTH'(RATIO);
    localparam logic [ADDR_WIDTH-1:0] c_one_ptr   = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] r_mem [c_depth];
    logic [ADDR_WIDTH-1:0] r_w_ptr;
    logic [ADDR_WIDTH-1:0] r_r_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_ovf;
    logic                  r_udf;

    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [ADDR_WIDTH:0]   w_count_nxt;
    logic [DATA_WIDTH-1:0] w_slice [RATIO];

    // Acceptance uses the pre-edge flags, so a same-cycle pop never frees room
    // for a push and a same-cycle push never feeds a pop on an empty FIFO.
    assign w_wr_acc = bus.wr && !r_full;
    assign w_rd_acc = bus.rd && !r_empty;

    // Slice k is stored at w_ptr+k and therefore read k-th.
    for (genvar k = 0; k < RATIO; k++) begin : g_slice
        if (WR_MSB_FIRST != 0) begin : g_msb
            assign w_slice[k] = bus.w_data[(RATIO-k)*DATA_WIDTH-1 -: DATA_WIDTH];
        end else begin : g_lsb
            assign w_slice[k] = bus.w_data[(k+1)*DATA_WIDTH-1 -: DATA_WIDTH];
        end
    end

    always_comb begin
        w_count_nxt = r_count;
        if (w_wr_acc) begin
            w_count_nxt = w_count_nxt + c_ratio_cnt;
        end
        if (w_rd_acc) begin
            w_count_nxt = w_count_nxt - c_one_cnt;
        end
    end

    // w_ptr is always RATIO-aligned, so the k offsets never wrap mid-word.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            for (int k = 0; k < RATIO; k++) begin
                r_mem[r_w_ptr + ADDR_WIDTH'(k)] <= w_slice[k];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_w_ptr <= '0;
            r_r_ptr <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_w_ptr <= r_w_ptr + c_ratio_ptr;
            end
            if (w_rd_acc) begin
                r_r_ptr <= r_r_ptr + c_one_ptr;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt > c_full_thresh);
            r_empty <= (w_count_nxt == '0);
            r_ovf   <= bus.wr && r_full;
            r_udf   <= bus.rd && r_empty;
        end
    end

    assign bus.r_data = r_empty ? '0 : r_mem[r_r_ptr];
    assign bus.full   = r_full;
    assign bus.empty  = r_empty;
    assign bus.count  = r_count;
    assign bus.ovf    = r_ovf;
    assign bus.udf    = r_udf;

endmodule
`default_nettype wire

// File: tb/tb_asym_fifo_wide_wr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_asym_fifo_wide_wr : directed bench for asym_fifo_wide_wr (both orders)   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_asym_fifo_wide_wr;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int RT = 2;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_errors;

    asym_fifo_wide_wr_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RATIO(RT)) bus ();
    asym_fifo_wide_wr_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RATIO(RT)) bus_lsb ();

    asym_fifo_wide_wr #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RATIO(RT), .WR_MSB_FIRST(1)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    asym_fifo_wide_wr #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RATIO(RT), .WR_MSB_FIRST(0)) dut_lsb (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_lsb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [15:0] wdata;
        logic        rd;
        logic [7:0]  exp_rdata;
        logic [4:0]  exp_count;
        logic        exp_empty;
        logic        exp_full;
        logic        exp_ovf;
        logic        exp_udf;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic w, input logic [15:0] d, input logic r);
        bus.wr     = w;
        bus.w_data = d;
        bus.rd     = r;
        @(posedge clk);
        #1;
        bus.wr = 1'b0;
        bus.rd = 1'b0;
    endtask

    task automatic check_state(input string tag, input logic [7:0] rdata, input logic [4:0] cnt,
                               input logic emp, input logic ful, input logic ov, input logic ud);
        check({tag, ".r_data"}, 32'(bus.r_data), 32'(rdata));
        check({tag, ".count"},  32'(bus.count),  32'(cnt));
        check({tag, ".empty"},  32'(bus.empty),  32'(emp));
        check({tag, ".full"},   32'(bus.full),   32'(ful));
        check({tag, ".ovf"},    32'(bus.ovf),    32'(ov));
        check({tag, ".udf"},    32'(bus.udf),    32'(ud));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset_n  = 1'b0;
        bus.wr = 1'b0; bus.rd = 1'b0; bus.w_data = '0;
        bus_lsb.wr = 1'b0; bus_lsb.rd = 1'b0; bus_lsb.w_data = '0;

        // wr, wdata, rd | r_data, count, empty, full, ovf, udf
        vecs[0]  = '{1'b1, 16'hA1B2, 1'b0, 8'hA1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 16'h0000, 1'b1, 8'hB2, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 16'h0000, 1'b1, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 16'h0000, 1'b1, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 16'h0000, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 16'h3344, 1'b1, 8'h33, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 16'h0000, 1'b0, 8'h33, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 16'h0000, 1'b1, 8'h44, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 16'h5566, 1'b1, 8'h55, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 16'h0000, 1'b1, 8'h66, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 16'h0000, 1'b1, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        check_state("reset", 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic order, underflow, and simultaneous push/pop on empty and non-empty.
        for (int i = 0; i < 11; i++) begin
            step(vecs[i].wr, vecs[i].wdata, vecs[i].rd);
            check_state($sformatf("vec%0d", i), vecs[i].exp_rdata, vecs[i].exp_count,
                        vecs[i].exp_empty, vecs[i].exp_full, vecs[i].exp_ovf, vecs[i].exp_udf);
        end

        // Fill to full, overflow, then drain (pointers start mid-array, so this wraps).
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, {8'h00, 8'(i)}, 1'b0);
            check($sformatf("fill%0d.count", i), 32'(bus.count), 32'(2*i));
            check($sformatf("fill%0d.full", i), 32'(bus.full), 32'(i == 8));
        end
        step(1'b1, 16'h0009, 1'b0);
        check_state("ovf", 8'h00, 5'd16, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 16'h0000, 1'b0);
        check("ovf_clear", 32'(bus.ovf), 32'd0);
        for (int j = 0; j < 16; j++) begin
            check($sformatf("drain%0d.r_data", j), 32'(bus.r_data),
                  (j % 2 == 0) ? 32'd0 : 32'(j/2 + 1));
            step(1'b0, 16'h0000, 1'b1);
        end
        check_state("drained", 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);

        // count=15 with full set: read wins, write dropped.
        for (int i = 0; i < 8; i++) step(1'b1, 16'h1111, 1'b0);
        step(1'b0, 16'h0000, 1'b1);
        check("c15.count", 32'(bus.count), 32'd15);
        check("c15.full", 32'(bus.full), 32'd1);
        step(1'b1, 16'h2222, 1'b1);
        check_state("c15_wr_rd", 8'h11, 5'd14, 1'b0, 1'b0, 1'b1, 1'b0);

        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Wrap: narrow sequence 0,1,2,... across index 15 -> 0.
        for (int i = 0; i < 8; i++) step(1'b1, {8'(2*i), 8'(2*i + 1)}, 1'b0);
        for (int j = 0; j < 6; j++) begin
            check($sformatf("wrapA%0d", j), 32'(bus.r_data), 32'(j));
            step(1'b0, 16'h0000, 1'b1);
        end
        for (int i = 8; i < 11; i++) step(1'b1, {8'(2*i), 8'(2*i + 1)}, 1'b0);
        check("wrap.count", 32'(bus.count), 32'd16);
        check("wrap.full", 32'(bus.full), 32'd1);
        for (int j = 0; j < 16; j++) begin
            check($sformatf("wrapB%0d", j), 32'(bus.r_data), 32'(6 + j));
            step(1'b0, 16'h0000, 1'b1);
        end
        check("wrap.empty", 32'(bus.empty), 32'd1);

        // Asynchronous reset between edges with count=7.
        for (int i = 0; i < 4; i++) step(1'b1, 16'hC0DE, 1'b0);
        step(1'b0, 16'h0000, 1'b1);
        check("pre_rst.count", 32'(bus.count), 32'd7);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst.count", 32'(bus.count), 32'd0);
        check("async_rst.empty", 32'(bus.empty), 32'd1);
        check("async_rst.r_data", 32'(bus.r_data), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Lower slice first.
        bus_lsb.wr = 1'b1;
        bus_lsb.w_data = 16'hA1B2;
        @(posedge clk);
        #1;
        bus_lsb.wr = 1'b0;
        check("lsb.first", 32'(bus_lsb.r_data), 32'h0B2);
        check("lsb.count", 32'(bus_lsb.count), 32'd2);
        bus_lsb.rd = 1'b1;
        @(posedge clk);
        #1;
        bus_lsb.rd = 1'b0;
        check("lsb.second", 32'(bus_lsb.r_data), 32'h0A1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
